// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose state bits are JK toggle cells.
// Drives a registered count, a one-cycle wrap pulse, a saturating wrap tally and a sticky bad-load flag.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              load_err
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    // One bit wider so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  q_next;
    logic [WIDTH-1:0]  step_val;
    logic [WIDTH-1:0]  load_d;
    logic              step_wrap;
    logic              load_oob;
    logic              count_wrap;
    logic              tc_reg;
    logic [WRAP_W-1:0] wrap_reg;
    logic              err_reg;

    always_comb begin
        step_wrap = 1'b0;
        step_val  = q_reg;
        if (up) begin
            if (q_reg == MAX_VAL) begin
                step_wrap = 1'b1;
                step_val  = '0;
            end else begin
                step_val = q_reg + 1'b1;
            end
        end else begin
            if (q_reg == '0) begin
                step_wrap = 1'b1;
                step_val  = MAX_VAL;
            end else begin
                step_val = q_reg - 1'b1;
            end
        end
    end

    assign load_oob   = ({1'b0, load_val} >= MOD_EXT);
    assign load_d     = load_oob ? MAX_VAL : load_val;
    assign count_wrap = en & ~load & step_wrap;

    // Per-bit JK cells: load forces J/K to the data, counting toggles only the bits that change.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic j_bit;
            logic k_bit;

            always_comb begin
                j_bit = 1'b0;
                k_bit = 1'b0;
                if (load) begin
                    j_bit = load_d[gi];
                    k_bit = ~load_d[gi];
                end else if (en) begin
                    j_bit = q_reg[gi] ^ step_val[gi];
                    k_bit = q_reg[gi] ^ step_val[gi];
                end
            end

            assign q_next[gi] = (j_bit & ~q_reg[gi]) | (~k_bit & q_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (res) begin
            q_reg    <= '0;
            tc_reg   <= 1'b0;
            wrap_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= count_wrap;
            if (count_wrap && (wrap_reg != '1)) begin
                wrap_reg <= wrap_reg + 1'b1;
            end
            if (load && load_oob) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign q        = q_reg;
    assign tc       = tc_reg;
    assign wrap_cnt = wrap_reg;
    assign load_err = err_reg;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a decade instance and a modulo-2 instance with a 2-bit wrap tally,
// both fed the same stimulus and checked each cycle against an integer-arithmetic model.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q0;
    logic       tc0;
    logic [7:0] wc0;
    logic       err0;
    logic [3:0] q1;
    logic       tc1;
    logic [1:0] wc1;
    logic       err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(8)) dut (
        .clk(clk), .res(res), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q0), .tc(tc0), .wrap_cnt(wc0), .load_err(err0)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(2), .WRAP_W(2)) dut_sat (
        .clk(clk), .res(res), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q1), .tc(tc1), .wrap_cnt(wc1), .load_err(err1)
    );

    // Behavioural model: index 0 = decade counter, index 1 = modulo-2 counter.
    int m_q[2];
    int m_tc[2];
    int m_wraps[2];
    int m_err[2];
    bit model_valid = 1'b0;

    function automatic int modulus_of(input int k);
        return (k == 0) ? 10 : 2;
    endfunction

    function automatic int sat_of(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic int m  = modulus_of(k);
            automatic int nq = m_q[k];
            automatic int nt = 0;
            automatic int nw = m_wraps[k];
            automatic int ne = m_err[k];
            if (res) begin
                nq = 0; nw = 0; ne = 0;
            end else if (load) begin
                if (int'(load_val) < m) nq = int'(load_val);
                else begin nq = m - 1; ne = 1; end
            end else if (en) begin
                if (up) nq = (m_q[k] + 1) % m;
                else    nq = (m_q[k] + m - 1) % m;
                nt = ((up && m_q[k] == m - 1) || (!up && m_q[k] == 0)) ? 1 : 0;
                nw = m_wraps[k] + nt;
            end
            m_q[k]     <= nq;
            m_tc[k]    <= nt;
            m_wraps[k] <= nw;
            m_err[k]   <= ne;
        end
        if (res) model_valid <= 1'b1;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int exp_wc(input int k);
        return (m_wraps[k] > sat_of(k)) ? sat_of(k) : m_wraps[k];
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("m0_q",   int'(q0),   m_q[0]);
            check("m0_tc",  int'(tc0),  m_tc[0]);
            check("m0_wc",  int'(wc0),  exp_wc(0));
            check("m0_err", int'(err0), m_err[0]);
            check("m1_q",   int'(q1),   m_q[1]);
            check("m1_tc",  int'(tc1),  m_tc[1]);
            check("m1_wc",  int'(wc1),  exp_wc(1));
            check("m1_err", int'(err1), m_err[1]);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
        res = r; en = e; up = u; load = l; load_val = v;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // T1: reset dominates en and load
        cyc(1, 1, 1, 1, 4'd5);
        cyc(1, 1, 1, 1, 4'd5);
        check("t1_q", int'(q0), 0);
        check("t1_tc", int'(tc0), 0);
        check("t1_wc", int'(wc0), 0);
        check("t1_err", int'(err0), 0);
        $display("T1 reset q=%0d tc=%0d wc=%0d err=%0d", q0, tc0, wc0, err0);

        // T2: up count through a wrap
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 1, 0, 4'd0);
            check("t2_q", int'(q0), (i + 1) % 10);
            check("t2_tc", int'(tc0), (i == 9) ? 1 : 0);
        end
        check("t2_wc", int'(wc0), 1);
        $display("T2 up q=%0d wc=%0d", q0, wc0);

        // T3: down wrap from 0
        cyc(0, 0, 0, 1, 4'd0);
        check("t3_load0", int'(q0), 0);
        cyc(0, 1, 0, 0, 4'd0);
        check("t3_q9", int'(q0), 9);
        check("t3_tc", int'(tc0), 1);
        cyc(0, 1, 0, 0, 4'd0);
        check("t3_q8", int'(q0), 8);
        check("t3_tc8", int'(tc0), 0);
        cyc(0, 1, 0, 0, 4'd0);
        check("t3_q7", int'(q0), 7);
        check("t3_wc", int'(wc0), 2);
        $display("T3 down q=%0d wc=%0d", q0, wc0);

        // T4: load beats count; out-of-range load clamps and sticks
        cyc(0, 1, 1, 1, 4'd7);
        check("t4_q7", int'(q0), 7);
        check("t4_tc", int'(tc0), 0);
        cyc(0, 0, 1, 1, 4'd12);
        check("t4_q9", int'(q0), 9);
        check("t4_err", int'(err0), 1);
        cyc(0, 0, 1, 1, 4'd3);
        check("t4_q3", int'(q0), 3);
        check("t4_err_sticky", int'(err0), 1);
        $display("T4 load q=%0d err=%0d", q0, err0);

        // T5: hold with up toggling
        cyc(0, 0, 0, 1, 4'd4);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, logic'(i % 2), 0, 4'd0);
            check("t5_q", int'(q0), 4);
            check("t5_tc", int'(tc0), 0);
        end
        $display("T5 hold q=%0d", q0);

        // T6: reset on the wrapping edge, then saturation on the 2-bit tally
        cyc(0, 0, 1, 1, 4'd9);
        cyc(1, 1, 1, 0, 4'd0);
        check("t6_q", int'(q0), 0);
        check("t6_tc", int'(tc0), 0);
        check("t6_wc", int'(wc0), 0);
        check("t6_err", int'(err0), 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 4'd0);
        check("t6_sat_wc", int'(wc1), 3);
        check("t6_main_wc", int'(wc0), 1);
        $display("T6 reset/sat wc0=%0d wc1=%0d", wc0, wc1);

        // Random phase, scored by the model-compare process
        for (int i = 0; i < 3000; i++) begin
            automatic int r = $urandom_range(0, 99);
            cyc(logic'(r == 0), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                logic'(r > 0 && r < 9), 4'($urandom_range(0, 15)));
        end
        $display("RANDOM done q0=%0d wc0=%0d q1=%0d wc1=%0d", q0, wc0, q1, wc1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
